// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller.
//   - funct3 codes for loads and stores
//   - cache_state_t : controller FSM states
//   - address-field width helpers (offset / index / tag)
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        DONE      = 2'd3
    } cache_state_t;

    // Byte-offset bits within a line: word select plus the two byte bits.
    function automatic int offset_bits(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_sets,
                                    input int block_words);
        return addr_width - offset_bits(block_words) - index_bits(num_sets);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Beat-wise memory bus between the data cache and backing memory.
//   mem_req   : beat request (cache -> memory)
//   mem_we    : 1 = write beat, 0 = read beat
//   mem_addr  : byte address of the current word beat
//   mem_wdata : write-beat data
//   mem_rdata : read-beat data (memory -> cache)
//   mem_ready : beat completes this cycle
interface dcache_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_ctrl_ls_align.sv
// Load/store alignment for one 32-bit cache word.
//   funct3     : access size and sign
//   byte_off   : address bits [1:0]
//   word_in    : current word from the line
//   store_data : right-aligned store data from the CPU
//   load_data  : extracted and sign/zero-extended load result
//   store_word : word_in with the store's byte lanes merged in
// Halfword accesses ignore byte_off[0]; word accesses ignore both bits.
module ls_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] byte_shift_s;
    logic [31:0] half_shift_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  lane_mask_s;
    logic [31:0] lane_data_s;

    // Load extraction and extension
    always_comb begin
        byte_shift_s = word_in >> {byte_off, 3'b000};
        half_shift_s = word_in >> {byte_off[1], 4'b0000};
        byte_s       = byte_shift_s[7:0];
        half_s       = half_shift_s[15:0];
        case (funct3)
            LB:      load_data = {{24{byte_s[7]}}, byte_s};
            LH:      load_data = {{16{half_s[15]}}, half_s};
            LBU:     load_data = {24'd0, byte_s};
            LHU:     load_data = {16'd0, half_s};
            default: load_data = word_in;
        endcase
    end

    // Store lane mask and byte-lane merge
    always_comb begin
        case (funct3)
            SB: begin
                lane_mask_s = 4'b0001 << byte_off;
                lane_data_s = {4{store_data[7:0]}};
            end
            SH: begin
                lane_mask_s = 4'b0011 << {byte_off[1], 1'b0};
                lane_data_s = {2{store_data[15:0]}};
            end
            default: begin
                lane_mask_s = 4'b1111;
                lane_data_s = store_data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (lane_mask_s[i]) begin
                store_word[8*i +: 8] = lane_data_s[8*i +: 8];
            end else begin
                store_word[8*i +: 8] = word_in[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
//   clk, rst_n       : clock, asynchronous active-low reset
//   cpu_addr/wdata   : MEM-stage byte address and right-aligned store data
//   cpu_we/cpu_re    : store / load request (store wins if both)
//   funct3           : access size and sign
//   cpu_rdata        : load result (combinational on a completing access)
//   stall            : pipeline hold during a miss
//   mem_bus          : beat-wise memory handshake (master side)
// Hits complete with no stall. A miss picks a victim (first invalid way,
// else LRU), writes it back if dirty, refills the requested line, then
// completes the access in DONE.
module dcache_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SETS    = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    dcache_ctrl_if.master         mem_bus
);

    localparam int OFFSET_W = offset_bits(BLOCK_WORDS);
    localparam int INDEX_W  = index_bits(NUM_SETS);
    localparam int TAG_W    = tag_bits(ADDR_WIDTH, NUM_SETS, BLOCK_WORDS);
    localparam int WSEL_W   = $clog2(BLOCK_WORDS);

    // Storage
    logic [DATA_WIDTH-1:0]    data_r [0:1][0:NUM_SETS-1][0:BLOCK_WORDS-1];
    logic [TAG_W-1:0]         tag_r  [0:1][0:NUM_SETS-1];
    logic [1:0][NUM_SETS-1:0] valid_r;
    logic [1:0][NUM_SETS-1:0] dirty_r;
    logic [NUM_SETS-1:0]      lru_r;      // way to evict next in each set

    // Controller state
    cache_state_t             state_r;
    logic [WSEL_W-1:0]        beat_r;
    logic                     victim_way_r;
    logic [INDEX_W-1:0]       idx_r;
    logic [TAG_W-1:0]         req_tag_r;
    logic [TAG_W-1:0]         wb_tag_r;
    logic [DATA_WIDTH-1:0]    rdata_hold_r;

    // Request decode
    logic                     req_s;
    logic [INDEX_W-1:0]       idx_s;
    logic [TAG_W-1:0]         tag_s;
    logic [WSEL_W-1:0]        wsel_s;
    logic                     hit0_s;
    logic                     hit1_s;
    logic                     hit_s;
    logic                     hit_way_s;
    logic                     victim_s;
    logic                     victim_dirty_s;
    logic                     complete_s;
    logic                     miss_s;
    logic                     beat_last_s;

    logic [DATA_WIDTH-1:0]    hit_load_s;
    logic [DATA_WIDTH-1:0]    hit_store_s;
    logic [DATA_WIDTH-1:0]    done_load_s;
    logic [DATA_WIDTH-1:0]    done_store_s;
    logic [DATA_WIDTH-1:0]    load_s;

    assign req_s       = cpu_re | cpu_we;
    assign idx_s       = cpu_addr[OFFSET_W +: INDEX_W];
    assign tag_s       = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign wsel_s      = cpu_addr[2 +: WSEL_W];
    assign beat_last_s = (beat_r == WSEL_W'(BLOCK_WORDS - 1));

    // Tag lookup, victim choice and access outcome
    always_comb begin
        hit0_s    = valid_r[0][idx_s] && (tag_r[0][idx_s] == tag_s);
        hit1_s    = valid_r[1][idx_s] && (tag_r[1][idx_s] == tag_s);
        hit_s     = hit0_s | hit1_s;
        hit_way_s = ~hit0_s & hit1_s;
        if (!valid_r[0][idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_s];
        end
        victim_dirty_s = valid_r[victim_s][idx_s] & dirty_r[victim_s][idx_s];
        complete_s = req_s && (((state_r == IDLE) && hit_s) || (state_r == DONE));
        miss_s     = req_s && (state_r == IDLE) && !hit_s;
    end

    ls_align u_align_hit (
        .funct3     (funct3),
        .byte_off   (cpu_addr[1:0]),
        .word_in    (data_r[hit_way_s][idx_s][wsel_s]),
        .store_data (cpu_wdata),
        .load_data  (hit_load_s),
        .store_word (hit_store_s)
    );

    ls_align u_align_done (
        .funct3     (funct3),
        .byte_off   (cpu_addr[1:0]),
        .word_in    (data_r[victim_way_r][idx_r][wsel_s]),
        .store_data (cpu_wdata),
        .load_data  (done_load_s),
        .store_word (done_store_s)
    );

    // CPU-side outputs; stall is forced low while reset is asserted
    always_comb begin
        if (state_r == DONE) begin
            load_s = done_load_s;
        end else begin
            load_s = hit_load_s;
        end
        if (complete_s && !cpu_we) begin
            cpu_rdata = load_s;
        end else begin
            cpu_rdata = rdata_hold_r;
        end
        stall = rst_n && (miss_s || (state_r == WRITEBACK) || (state_r == REFILL));
    end

    // Memory bus outputs, derived only from registered state so they hold
    // steady while mem_ready is low
    always_comb begin
        case (state_r)
            WRITEBACK: begin
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = 1'b1;
                mem_bus.mem_addr  = {wb_tag_r, idx_r, beat_r, 2'b00};
                mem_bus.mem_wdata = data_r[victim_way_r][idx_r][beat_r];
            end
            REFILL: begin
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = 1'b0;
                mem_bus.mem_addr  = {req_tag_r, idx_r, beat_r, 2'b00};
                mem_bus.mem_wdata = {DATA_WIDTH{1'b0}};
            end
            default: begin
                mem_bus.mem_req   = 1'b0;
                mem_bus.mem_we    = 1'b0;
                mem_bus.mem_addr  = {ADDR_WIDTH{1'b0}};
                mem_bus.mem_wdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Controller FSM with valid/dirty/LRU bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            beat_r       <= {WSEL_W{1'b0}};
            victim_way_r <= 1'b0;
            idx_r        <= {INDEX_W{1'b0}};
            req_tag_r    <= {TAG_W{1'b0}};
            wb_tag_r     <= {TAG_W{1'b0}};
            rdata_hold_r <= {DATA_WIDTH{1'b0}};
            valid_r      <= '0;
            dirty_r      <= '0;
            lru_r        <= {NUM_SETS{1'b0}};
        end else begin
            if (complete_s && !cpu_we) begin
                rdata_hold_r <= load_s;
            end
            case (state_r)
                IDLE: begin
                    if (complete_s) begin
                        lru_r[idx_s] <= ~hit_way_s;
                        if (cpu_we) begin
                            dirty_r[hit_way_s][idx_s] <= 1'b1;
                        end
                    end else if (miss_s) begin
                        victim_way_r <= victim_s;
                        idx_r        <= idx_s;
                        req_tag_r    <= tag_s;
                        wb_tag_r     <= tag_r[victim_s][idx_s];
                        beat_r       <= {WSEL_W{1'b0}};
                        state_r      <= victim_dirty_s ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_bus.mem_ready) begin
                        if (beat_last_s) begin
                            beat_r  <= {WSEL_W{1'b0}};
                            state_r <= REFILL;
                        end else begin
                            beat_r <= beat_r + WSEL_W'(1);
                        end
                    end
                end
                REFILL: begin
                    if (mem_bus.mem_ready) begin
                        if (beat_last_s) begin
                            beat_r                      <= {WSEL_W{1'b0}};
                            valid_r[victim_way_r][idx_r] <= 1'b1;
                            dirty_r[victim_way_r][idx_r] <= 1'b0;
                            state_r                     <= DONE;
                        end else begin
                            beat_r <= beat_r + WSEL_W'(1);
                        end
                    end
                end
                DONE: begin
                    lru_r[idx_r] <= ~victim_way_r;
                    if (cpu_we) begin
                        dirty_r[victim_way_r][idx_r] <= 1'b1;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Line data and tags; left unreset because valid gates every use
    always_ff @(posedge clk) begin
        if ((state_r == IDLE) && complete_s && cpu_we) begin
            data_r[hit_way_s][idx_s][wsel_s] <= hit_store_s;
        end else if ((state_r == DONE) && cpu_we) begin
            data_r[victim_way_r][idx_r][wsel_s] <= done_store_s;
        end else if ((state_r == REFILL) && mem_bus.mem_ready) begin
            data_r[victim_way_r][idx_r][beat_r] <= mem_bus.mem_rdata;
            if (beat_last_s) begin
                tag_r[victim_way_r][idx_r] <= req_tag_r;
            end
        end
    end

endmodule
